// File: rtl/compositor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : compositor_pkg
//  Description : Shared state encoding and legal parameter ranges for the
//                layer compositor.
//  Revision    : 1.0  initial release
// ============================================================================
package compositor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LAYER  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } comp_state_t;

    localparam int c_MIN_LAYERS    = 1;
    localparam int c_MAX_LAYERS    = 8;
    localparam int c_MIN_READ_LAT  = 1;
    localparam int c_MAX_READ_LAT  = 4;
    localparam int c_MAX_FRAME_DIM = 512;
    localparam int c_RENDER_XY_W   = 9;

endpackage
`default_nettype wire

// File: rtl/pixel_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_scan_counter
//  Description : Raster x/y counter; x runs fastest, wraps to (0,0) after the
//                last pixel of the frame.
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_scan_counter #(
    parameter int FRAME_W = 256,
    parameter int FRAME_H = 256,
    parameter int X_W     = 8,
    parameter int Y_W     = 8
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           i_en,
    input  logic           i_clr,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last
);

    localparam logic [X_W-1:0] c_X_MAX = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0] c_Y_MAX = Y_W'(FRAME_H - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           w_x_end;
    logic           w_y_end;

    assign w_x_end = (r_x == c_X_MAX);
    assign w_y_end = (r_y == c_Y_MAX);
    assign o_last  = w_x_end & w_y_end;
    assign o_x     = r_x;
    assign o_y     = r_y;

    // Advance one pixel per enabled cycle in raster order, wrapping at frame end.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_en) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : layer_compositor
//  Description : Clears the framebuffer then paints each enabled source layer
//                in index order, skipping transparent pixels. A stalled write
//                freezes the whole block until the framebuffer accepts it.
//  Revision    : 1.0  initial release
// ============================================================================
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int               NUM_LAYERS  = 3,
    parameter int               FRAME_W     = 256,
    parameter int               FRAME_H     = 256,
    parameter int               PIX_W       = 4,
    parameter int               OUT_W       = 16,
    parameter int               READ_LAT    = 1,
    parameter logic [PIX_W-1:0] TRANSPARENT = '0,
    parameter logic [OUT_W-1:0] CLEAR_COLOR = '0,
    localparam int              c_LSEL_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int              c_X_W       = (FRAME_W > 1) ? $clog2(FRAME_W) : 1,
    localparam int              c_Y_W       = (FRAME_H > 1) ? $clog2(FRAME_H) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     VS,
    input  logic [NUM_LAYERS-1:0]    LAYER_EN,
    input  logic                     WR_READY,
    output logic [c_LSEL_W-1:0]      LAYER_SEL,
    output logic [c_X_W-1:0]         SRC_X,
    output logic [c_Y_W-1:0]         SRC_Y,
    output logic                     SRC_RE,
    input  logic [PIX_W-1:0]         SRC_DATA,
    output logic                     RENDER_EN,
    output logic [OUT_W-1:0]         RENDER_DATA,
    output logic [c_RENDER_XY_W-1:0] RENDER_X,
    output logic [c_RENDER_XY_W-1:0] RENDER_Y,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     FRAME_DROP
);

    if (NUM_LAYERS < c_MIN_LAYERS || NUM_LAYERS > c_MAX_LAYERS ||
        READ_LAT < c_MIN_READ_LAT || READ_LAT > c_MAX_READ_LAT ||
        FRAME_W < 1 || FRAME_W > c_MAX_FRAME_DIM ||
        FRAME_H < 1 || FRAME_H > c_MAX_FRAME_DIM || OUT_W < PIX_W) begin : g_param_check
        $error("layer_compositor: parameter out of range");
    end

    comp_state_t           r_state;
    comp_state_t           w_state_nxt;
    logic                  r_vs_d1;
    logic                  r_vs_d2;
    logic [1:0]            r_arm;
    logic                  w_vs_fall;
    logic [NUM_LAYERS-1:0] r_pending;
    logic [c_LSEL_W-1:0]   r_layer;
    logic [c_LSEL_W-1:0]   w_first_layer;
    logic [1:0]            r_drain;
    logic                  w_stall;
    logic                  w_issue;
    logic                  w_cnt_en;
    logic                  w_cnt_clr;
    logic                  w_latch;
    logic                  w_take;
    logic                  w_drain_step;
    logic [c_X_W-1:0]      w_x;
    logic [c_Y_W-1:0]      w_y;
    logic                  w_last;
    logic [READ_LAT-1:0]   r_pipe_v;
    logic [c_X_W-1:0]      r_pipe_x [READ_LAT];
    logic [c_Y_W-1:0]      r_pipe_y [READ_LAT];

    pixel_scan_counter #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .X_W     (c_X_W),
        .Y_W     (c_Y_W)
    ) u_scan (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_en    (w_cnt_en),
        .i_clr   (w_cnt_clr),
        .o_x     (w_x),
        .o_y     (w_y),
        .o_last  (w_last)
    );

    // VS sampler; the arm bits mask any edge seen right after reset release.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vs_d1 <= 1'b1;
            r_vs_d2 <= 1'b1;
            r_arm   <= 2'b00;
        end else begin
            r_vs_d1 <= VS;
            r_vs_d2 <= r_vs_d1;
            r_arm   <= {r_arm[0], 1'b1};
        end
    end

    assign w_vs_fall  = r_vs_d2 & ~r_vs_d1 & r_arm[1];
    assign FRAME_DROP = w_vs_fall & (r_state != ST_IDLE);
    assign BUSY       = (r_state != ST_IDLE);
    assign LAYER_SEL  = r_layer;

    // Lowest-numbered layer still waiting to be drawn this frame.
    always_comb begin
        w_first_layer = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_first_layer = c_LSEL_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, write request and stall decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_en     = 1'b0;
        w_cnt_clr    = 1'b0;
        w_issue      = 1'b0;
        w_latch      = 1'b0;
        w_take       = 1'b0;
        w_drain_step = 1'b0;
        w_stall      = 1'b0;
        SRC_RE       = 1'b0;
        SRC_X        = '0;
        SRC_Y        = '0;
        RENDER_EN    = 1'b0;
        RENDER_DATA  = '0;
        RENDER_X     = '0;
        RENDER_Y     = '0;
        DONE         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_fall) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_clr   = 1'b1;
                    w_latch     = 1'b1;
                end
            end
            ST_CLEAR: begin
                RENDER_EN   = 1'b1;
                RENDER_DATA = CLEAR_COLOR;
                RENDER_X    = c_RENDER_XY_W'(w_x);
                RENDER_Y    = c_RENDER_XY_W'(w_y);
                w_stall     = ~WR_READY;
                w_cnt_en    = ~w_stall;
                if (w_last && !w_stall) begin
                    if (|r_pending) begin
                        w_state_nxt = ST_LAYER;
                        w_take      = 1'b1;
                    end else begin
                        w_state_nxt = ST_FINISH;
                    end
                end
            end
            ST_LAYER, ST_DRAIN: begin
                RENDER_EN   = r_pipe_v[READ_LAT-1] && (SRC_DATA != TRANSPARENT);
                RENDER_DATA = r_pipe_v[READ_LAT-1] ? OUT_W'(SRC_DATA) : '0;
                RENDER_X    = c_RENDER_XY_W'(r_pipe_x[READ_LAT-1]);
                RENDER_Y    = c_RENDER_XY_W'(r_pipe_y[READ_LAT-1]);
                w_stall     = RENDER_EN & ~WR_READY;
                if (r_state == ST_LAYER) begin
                    SRC_RE   = ~w_stall;
                    SRC_X    = w_x;
                    SRC_Y    = w_y;
                    w_issue  = ~w_stall;
                    w_cnt_en = ~w_stall;
                    if (w_last && !w_stall) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else begin
                    w_drain_step = ~w_stall;
                    if (!w_stall && r_drain == 2'(READ_LAT - 1)) begin
                        if (|r_pending) begin
                            w_state_nxt = ST_LAYER;
                            w_take      = 1'b1;
                        end else begin
                            w_state_nxt = ST_FINISH;
                        end
                    end
                end
            end
            ST_FINISH: begin
                DONE        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Layer bookkeeping: latch enables at start, pop one layer per entry to LAYER.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pending <= '0;
            r_layer   <= '0;
            r_drain   <= '0;
        end else begin
            if (w_latch) begin
                r_pending <= LAYER_EN;
                r_drain   <= '0;
            end
            if (w_drain_step) begin
                r_drain <= r_drain + 1'b1;
            end
            if (w_take) begin
                r_layer                  <= w_first_layer;
                r_pending[w_first_layer] <= 1'b0;
                r_drain                  <= '0;
            end
        end
    end

    // Read-latency pipeline carrying {valid, x, y}; holds while stalled.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pipe_v <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_pipe_x[i] <= '0;
                r_pipe_y[i] <= '0;
            end
        end else if (!w_stall) begin
            r_pipe_v[0] <= w_issue;
            r_pipe_x[0] <= w_x;
            r_pipe_y[0] <= w_y;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_x[i] <= r_pipe_x[i-1];
                r_pipe_y[i] <= r_pipe_y[i-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_compositor
//  Description : Self-checking bench for layer_compositor (4x2 frame, three
//                layers, read latency 1) with a write scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_layer_compositor;

    localparam int          NL = 3;
    localparam int          FW = 4;
    localparam int          FH = 2;
    localparam logic [15:0] CC = 16'h00C3;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        VS = 1'b1;
    logic [2:0]  LAYER_EN = 3'b000;
    logic        WR_READY = 1'b1;
    logic [1:0]  LAYER_SEL;
    logic [1:0]  SRC_X;
    logic        SRC_Y;
    logic        SRC_RE;
    logic [3:0]  SRC_DATA;
    logic        RENDER_EN;
    logic [15:0] RENDER_DATA;
    logic [8:0]  RENDER_X;
    logic [8:0]  RENDER_Y;
    logic        BUSY;
    logic        DONE;
    logic        FRAME_DROP;

    layer_compositor #(
        .NUM_LAYERS  (NL),
        .FRAME_W     (FW),
        .FRAME_H     (FH),
        .PIX_W       (4),
        .OUT_W       (16),
        .READ_LAT    (1),
        .TRANSPARENT (4'h0),
        .CLEAR_COLOR (CC)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .VS          (VS),
        .LAYER_EN    (LAYER_EN),
        .WR_READY    (WR_READY),
        .LAYER_SEL   (LAYER_SEL),
        .SRC_X       (SRC_X),
        .SRC_Y       (SRC_Y),
        .SRC_RE      (SRC_RE),
        .SRC_DATA    (SRC_DATA),
        .RENDER_EN   (RENDER_EN),
        .RENDER_DATA (RENDER_DATA),
        .RENDER_X    (RENDER_X),
        .RENDER_Y    (RENDER_Y),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .FRAME_DROP  (FRAME_DROP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] en;
        logic [3:0] p0, p1, p2;
        int zero_x, stall_at, stall_len, drop_at;
        int exp_busy, exp_writes, exp_drops;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int d;
    } wr_t;

    vec_t       vecs [7];
    wr_t        sbq [$];
    logic [3:0] cur_pix [NL];
    logic [2:0] cur_en = 3'b000;
    int         cur_zero_x = -1;
    logic [3:0] src_q = 4'h0;
    int checks = 0, errors = 0;
    int busy_cnt = 0, done_cnt = 0, drop_cnt = 0, wr_cnt = 0;

    // Source model: one-cycle read latency, holds output while SRC_RE is low.
    function automatic logic [3:0] pix_fn(input int l, input int x);
        if (l >= NL) return 4'h0;
        if (x == cur_zero_x) return 4'h0;
        return cur_pix[l];
    endfunction

    always @(posedge CLK) begin
        if (SRC_RE) src_q <= pix_fn(int'(LAYER_SEL), int'(SRC_X));
    end
    assign SRC_DATA = src_q;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected write stream: clear fill, then each enabled layer's opaque pixels.
    task automatic build_expect();
        wr_t e;
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) begin
                e.x = x; e.y = y; e.d = int'(CC);
                sbq.push_back(e);
            end
        for (int l = 0; l < NL; l++)
            if (cur_en[l])
                for (int y = 0; y < FH; y++)
                    for (int x = 0; x < FW; x++)
                        if (pix_fn(l, x) != 4'h0) begin
                            e.x = x; e.y = y; e.d = int'(pix_fn(l, x));
                            sbq.push_back(e);
                        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge CLK);
            if (RESET_N) begin
                if (BUSY) busy_cnt++;
                if (DONE) done_cnt++;
                if (FRAME_DROP) drop_cnt++;
                if (SRC_RE)
                    chk("layer_sel_enabled",
                        (int'(LAYER_SEL) < NL) ? int'(cur_en[LAYER_SEL]) : 0, 1);
                if (RENDER_EN) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        chk("render_x", int'(RENDER_X), sbq[0].x);
                        chk("render_y", int'(RENDER_Y), sbq[0].y);
                        chk("render_data", int'(RENDER_DATA), sbq[0].d);
                        if (WR_READY) begin
                            void'(sbq.pop_front());
                            wr_cnt++;
                        end else begin
                            chk("src_re_in_stall", int'(SRC_RE), 0);
                        end
                    end
                end
            end
        end
    endtask

    task automatic load_vec(input vec_t v);
        cur_en     = v.en;
        cur_pix[0] = v.p0;
        cur_pix[1] = v.p1;
        cur_pix[2] = v.p2;
        cur_zero_x = v.zero_x;
        LAYER_EN   = v.en;
        sbq.delete();
        build_expect();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int b0, d0, dr0, w0, bidx, cyc;
        bit seen_done;
        load_vec(v);
        b0 = busy_cnt; d0 = done_cnt; dr0 = drop_cnt; w0 = wr_cnt;
        VS = 1'b0;
        @(posedge CLK); #1;
        VS = 1'b1;
        bidx = 0; cyc = 0; seen_done = 0;
        while (!seen_done && cyc < 300) begin
            @(posedge CLK); #1;
            cyc++;
            VS = 1'b1;
            WR_READY = 1'b1;
            if (BUSY) begin
                LAYER_EN = ~v.en;
                if (v.stall_at >= 0 && bidx >= v.stall_at && bidx < v.stall_at + v.stall_len)
                    WR_READY = 1'b0;
                if (bidx == v.drop_at) VS = 1'b0;
                if (DONE) seen_done = 1;
                bidx++;
            end
        end
        chk($sformatf("v%0d_done_seen", idx), int'(seen_done), 1);
        repeat (3) @(posedge CLK);
        #1;
        chk($sformatf("v%0d_busy_cycles", idx), busy_cnt - b0, v.exp_busy);
        chk($sformatf("v%0d_done_pulses", idx), done_cnt - d0, 1);
        chk($sformatf("v%0d_frame_drops", idx), drop_cnt - dr0, v.exp_drops);
        chk($sformatf("v%0d_writes", idx), wr_cnt - w0, v.exp_writes);
        chk($sformatf("v%0d_scoreboard_left", idx), sbq.size(), 0);
        chk($sformatf("v%0d_idle_after", idx), int'(BUSY), 0);
        sbq.delete();
    endtask

    initial begin
        int d0, bidx, cyc;
        bit any_busy;
        vecs[0] = '{3'b111, 4'h5, 4'h5, 4'h5, -1, -1, 0, -1, 36, 32, 0};
        vecs[1] = '{3'b010, 4'h5, 4'h5, 4'h5,  2, -1, 0, -1, 18, 14, 0};
        vecs[2] = '{3'b111, 4'h5, 4'h5, 4'h5, -1, 10, 5, -1, 41, 32, 0};
        vecs[3] = '{3'b111, 4'h5, 4'h5, 4'h5, -1, -1, 0, 10, 36, 32, 1};
        vecs[4] = '{3'b000, 4'h5, 4'h5, 4'h5, -1, -1, 0, -1,  9,  8, 0};
        vecs[5] = '{3'b101, 4'h7, 4'h5, 4'h0, -1, -1, 0, -1, 27, 16, 0};
        vecs[6] = '{3'b011, 4'h9, 4'h4, 4'h5,  0,  3, 2, -1, 29, 20, 0};

        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_drop", int'(FRAME_DROP), 0);
        chk("rst_render_en", int'(RENDER_EN), 0);
        chk("rst_render_data", int'(RENDER_DATA), 0);
        chk("rst_render_xy", int'({RENDER_X, RENDER_Y}), 0);
        chk("rst_src_re", int'(SRC_RE), 0);
        chk("rst_src_xy", int'({SRC_X, SRC_Y}), 0);
        chk("rst_layer_sel", int'(LAYER_SEL), 0);
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Mid-frame reset: abort at busy cycle 20, then VS low across release.
        load_vec(vecs[0]);
        d0 = done_cnt;
        VS = 1'b0;
        @(posedge CLK); #1;
        VS = 1'b1;
        bidx = 0; cyc = 0;
        while (bidx < 20 && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
            if (BUSY) bidx++;
        end
        chk("abort_reached_cycle20", bidx, 20);
        #2;
        VS = 1'b0;
        RESET_N = 1'b0;
        #1;
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_render_en", int'(RENDER_EN), 0);
        chk("abort_src_re", int'(SRC_RE), 0);
        chk("abort_layer_sel", int'(LAYER_SEL), 0);
        chk("abort_render_xy", int'({RENDER_X, RENDER_Y}), 0);
        chk("abort_done", int'(DONE), 0);
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        any_busy = 0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (BUSY) any_busy = 1;
        end
        chk("no_start_after_release", int'(any_busy), 0);
        chk("abort_no_done", done_cnt - d0, 0);
        VS = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        run_vec(vecs[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
